// File: rtl/morse_decoder_if.sv
// Decoded-letter output bundle of morse_decoder. It feeds the seven-segment stage.
interface morse_decoder_if;
  logic [4:0] morse_out;
  logic       valid;
  logic       err;
  logic       busy;

  modport master (output morse_out, valid, err, busy);
  modport slave  (input  morse_out, valid, err, busy);
endinterface

// File: rtl/morse_decoder.sv
// morse_decoder: turns a single Morse key into letter indices (A=0..Z=25, 31=invalid).
// The key is synchronized and optionally debounced. Each press is classified as a dot
// or a dash by its length. A release longer than GAP_CYC ends the letter, and the letter
// is then looked up and strobed out for one cycle.
// Optional feature: define MORSE_DEBOUNCE_EN to build a DEBOUNCE_CYC-cycle debouncer on
// the key. Without it, the synchronized key is used as-is.
module morse_decoder #(
  parameter int DOT_MAX      = 12500000,
  parameter int GAP_CYC      = 37500000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int CNT_W        = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key,
  morse_decoder_if.master  mo
);

  localparam logic [CNT_W-1:0] DOT_MAX_C = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  // Reject parameter values for which the timing rules make no sense.
  if (DOT_MAX < 1 || GAP_CYC < 2 || DEBOUNCE_CYC < 1 || CNT_W < 2) begin : g_param_chk
    $error("morse_decoder: bad parameters");
  end

  typedef enum logic [1:0] {IDLE, MARK, SPACE, EMIT} state_t;

  // ---------------------------------------------------------------- synchronizer
  logic key_meta_q, key_meta_d, key_s_q, key_s_d, key_db;

  // Two-stage shift of the asynchronous key into the clock domain.
  always_comb begin
    key_meta_d = key;
    key_s_d    = key_meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_s_q    <= key_s_d;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  // ---------------------------------------------------------------- debouncer
  localparam int               DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            key_db_q, key_db_d;

  // Accept a new level only after it has differed for DEBOUNCE_CYC cycles in a row.
  // Any return to the accepted level restarts the count.
  always_comb begin
    db_cnt_d = '0;
    key_db_d = key_db_q;
    if (key_s_q != key_db_q) begin
      if (db_cnt_q == DB_LAST) key_db_d = key_s_q;
      else                     db_cnt_d = db_cnt_q + DB_W'(1);
    end
  end

  // Debounce state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt_q <= '0;
      key_db_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      key_db_q <= key_db_d;
    end
  end

  assign key_db = key_db_q;
`else
  assign key_db = key_s_q;
`endif

  // ---------------------------------------------------------------- letter table
  // The symbol is stored with the first element in the highest used bit. Only the low
  // n bits are meaningful, and the upper bits stay zero because sym is cleared per letter.
  function automatic logic [4:0] letter_of(input logic [2:0] n, input logic [3:0] s);
    logic [4:0] r;
    case ({n, s})
      {3'd1, 4'h0}: r = 5'd4;   // E .
      {3'd1, 4'h1}: r = 5'd19;  // T -
      {3'd2, 4'h0}: r = 5'd8;   // I ..
      {3'd2, 4'h1}: r = 5'd0;   // A .-
      {3'd2, 4'h2}: r = 5'd13;  // N -.
      {3'd2, 4'h3}: r = 5'd12;  // M --
      {3'd3, 4'h0}: r = 5'd18;  // S ...
      {3'd3, 4'h1}: r = 5'd20;  // U ..-
      {3'd3, 4'h2}: r = 5'd17;  // R .-.
      {3'd3, 4'h3}: r = 5'd22;  // W .--
      {3'd3, 4'h4}: r = 5'd3;   // D -..
      {3'd3, 4'h5}: r = 5'd10;  // K -.-
      {3'd3, 4'h6}: r = 5'd6;   // G --.
      {3'd3, 4'h7}: r = 5'd14;  // O ---
      {3'd4, 4'h0}: r = 5'd7;   // H ....
      {3'd4, 4'h1}: r = 5'd21;  // V ...-
      {3'd4, 4'h2}: r = 5'd5;   // F ..-.
      {3'd4, 4'h4}: r = 5'd11;  // L .-..
      {3'd4, 4'h6}: r = 5'd15;  // P .--.
      {3'd4, 4'h7}: r = 5'd9;   // J .---
      {3'd4, 4'h8}: r = 5'd1;   // B -...
      {3'd4, 4'h9}: r = 5'd23;  // X -..-
      {3'd4, 4'hA}: r = 5'd2;   // C -.-.
      {3'd4, 4'hB}: r = 5'd24;  // Y -.--
      {3'd4, 4'hC}: r = 5'd25;  // Z --..
      {3'd4, 4'hD}: r = 5'd16;  // Q --.-
      default:      r = 5'd31;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------- FSM + datapath
  state_t           state_q, state_d;
  logic [CNT_W-1:0] press_q, press_d, gap_q, gap_d;
  logic [3:0]       sym_q, sym_d;
  logic [2:0]       sym_cnt_q, sym_cnt_d;
  logic             ovf_q, ovf_d;
  logic [4:0]       morse_out_q, morse_out_d, code;
  logic             valid_q, valid_d, err_q, err_d;

  assign code = letter_of(sym_cnt_q, sym_q);

  // Next state, element capture and letter emission. Outputs are loaded on the
  // SPACE->EMIT edge, so the valid strobe coincides with the EMIT cycle.
  always_comb begin
    state_d     = state_q;
    press_d     = press_q;
    gap_d       = gap_q;
    sym_d       = sym_q;
    sym_cnt_d   = sym_cnt_q;
    ovf_d       = ovf_q;
    morse_out_d = morse_out_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_db) begin
          state_d = MARK;
          press_d = '0;
        end
      end
      MARK: begin
        if (key_db) begin
          if (!(&press_q)) press_d = press_q + CNT_W'(1);
        end else begin
          // A fifth element cannot fit, so mark the letter as bad and keep sym intact.
          if (sym_cnt_q == 3'd4) ovf_d = 1'b1;
          else begin
            sym_d     = {sym_q[2:0], (press_q >= DOT_MAX_C)};
            sym_cnt_d = sym_cnt_q + 3'd1;
          end
          state_d = SPACE;
          gap_d   = '0;
        end
      end
      SPACE: begin
        // Letter end wins over a press that lands on the same cycle.
        if (gap_q == GAP_LAST) begin
          state_d     = EMIT;
          valid_d     = 1'b1;
          err_d       = ovf_q || (code == 5'd31);
          morse_out_d = err_d ? 5'd31 : code;
        end else if (key_db) begin
          state_d = MARK;
          press_d = '0;
        end else begin
          gap_d = gap_q + CNT_W'(1);
        end
      end
      EMIT: begin
        sym_d     = '0;
        sym_cnt_d = '0;
        ovf_d     = 1'b0;
        press_d   = '0;
        state_d   = key_db ? MARK : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      press_q     <= '0;
      gap_q       <= '0;
      sym_q       <= '0;
      sym_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      morse_out_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      press_q     <= press_d;
      gap_q       <= gap_d;
      sym_q       <= sym_d;
      sym_cnt_q   <= sym_cnt_d;
      ovf_q       <= ovf_d;
      morse_out_q <= morse_out_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign mo.morse_out = morse_out_q;
  assign mo.valid     = valid_q;
  assign mo.err       = err_q;
  assign mo.busy      = (state_q == MARK) || (state_q == SPACE);

endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter DOT_MAX, default 12500000: debounced press shorter than this many cycles is a dot; otherwise it is a dash.
REQ-002 Parameter GAP_CYC, default 37500000: released duration, in cycles, that ends a letter.
REQ-003 Parameter DEBOUNCE_CYC, default 500000: consecutive stable cycles required to accept a key level change (with MORSE_DEBOUNCE_EN only).
REQ-004 Parameter CNT_W, default 26: width of the duration counters.
REQ-005 Port clk, input, 1: single clock; all state is rising-edge.
REQ-006 Port rst, input, 1: asynchronous, active-low reset.
REQ-007 Port key, input, 1: raw, asynchronous Morse key; 1 = pressed.
REQ-008 Port morse_out, output, 5: letter index A=0..Z=25, or 31 for an invalid pattern; drives the seven-segment stage's letter input.
REQ-009 Port valid, output, 1: one-cycle strobe; morse_out is new in this cycle; drives the seven-segment stage's inp.
REQ-010 Port err, output, 1: one-cycle strobe, coincident with valid, when the pattern is invalid.
REQ-011 Port busy, output, 1: high in states MARK and SPACE.

Function
REQ-012 key shall pass through a 2-flop synchronizer; the synchronized level is key_s.
REQ-013 Symbol register sym[3:0] and count sym_cnt[2:0] hold the current letter; each new element shifts in at the LSB (dot=0, dash=1).
REQ-014 The FSM shall have states IDLE, MARK, SPACE and EMIT.
REQ-015 IDLE: when key_db=1 -> MARK, with the press counter cleared.
REQ-016 MARK: press counter increments and saturates at 2^CNT_W-1.
REQ-017 MARK, on key_db=0: classify the element (count < DOT_MAX -> dot, else dash) and shift it in; sym_cnt increments; -> SPACE with the gap counter cleared.
REQ-018 If a fifth element arrives (sym_cnt already 4), an overflow flag shall set and sym is left unchanged.
REQ-019 SPACE: gap counter increments; key_db=1 before the count reaches GAP_CYC-1 -> MARK.
REQ-020 SPACE: on the cycle the gap count reaches GAP_CYC-1 -> EMIT; the letter end takes priority over a coincident press.
REQ-021 EMIT (exactly one cycle): map (sym, sym_cnt) through the ITU Morse table for A–Z and register the result onto morse_out.
REQ-022 EMIT: assert valid for that one cycle.
REQ-023 EMIT: a pattern that is not a letter, or overflow, gives morse_out=31 and err=1.
REQ-024 EMIT: clear sym, sym_cnt and overflow; key_db=1 -> MARK, else -> IDLE.
REQ-025 morse_out shall hold its last value between strobes.
REQ-026 Latency: valid rises exactly GAP_CYC+1 cycles after the final release is seen on key_db.
REQ-027 A press held at saturation is a dash; holding never emits.

Reset
REQ-028 While rst=0 (including mid-letter): FSM=IDLE; sym, sym_cnt, counters and overflow=0; synchronizer and debounce regs=0; morse_out=0; valid=err=busy=0.
REQ-029 The first press after reset release starts a fresh letter.

Configuration
REQ-030 Macro MORSE_DEBOUNCE_EN defined: key_db changes only after key_s differs from key_db for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
REQ-031 Macro MORSE_DEBOUNCE_EN undefined: key_db = key_s and no debounce logic is built.

Verification (DOT_MAX=4, GAP_CYC=10, DEBOUNCE_CYC=2)
REQ-032 Press 2 cycles, release 3, press 8, release 12 -> one valid, morse_out=0 (A), err=0.
REQ-033 Four 2-cycle presses separated by 3-cycle gaps, then an 11-cycle gap -> morse_out=7 (H); five such presses -> morse_out=31, err=1.
REQ-034 Dash-dash-dot-dash -> morse_out=16 (Q); a press that coincides with the gap-expiry cycle -> Q is emitted and the press starts the next letter.
REQ-035 rst=0 asserted in SPACE after two dots -> all outputs 0; then a single dot -> morse_out=4 (E).
REQ-036 With MORSE_DEBOUNCE_EN: a 1-cycle glitch on key -> no element registered and no valid.
